// File: rtl/rv_mem_resp.sv
// rv_mem_resp: word memory responder serving fetch/load/store over a req/ready/rvalid handshake with wait states
// Ports: clk, rst (async, active-high); req/we/neg/addr/wdata request side, held until ready;
//        ready (idle, accepts req), rvalid (one-cycle response strobe), rdata (load data), err (bad access).
module rv_mem_resp #(
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        we,
  input  logic        neg,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        ready,
  output logic        rvalid,
  output logic [31:0] rdata,
  output logic        err
);
  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [31:0] LIMIT = 32'(4 * DEPTH_WORDS);
  localparam logic [3:0] WC = 4'(WAIT_CYCLES);
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  state_t state;
  logic [3:0] cnt;
  logic c_we, c_neg;
  logic [31:0] c_addr, c_wdata;
  logic [31:0] mem [DEPTH_WORDS];
  logic idle_go, fire, a_we, a_neg, bad;
  logic [31:0] a_addr, a_wdata, sdata;
  logic [AW-1:0] idx;
  assign idle_go = state == IDLE && req;
  assign fire = (idle_go && WC == 4'd0) || (state == WAIT && cnt == 4'd1);
  // with zero wait states the access happens on the accept edge, before the capture registers load
  assign a_we = state == IDLE ? we : c_we;
  assign a_neg = state == IDLE ? neg : c_neg;
  assign a_addr = state == IDLE ? addr : c_addr;
  assign a_wdata = state == IDLE ? wdata : c_wdata;
  assign bad = a_addr[1:0] != 2'b00 || a_addr >= LIMIT;
  assign idx = a_addr[AW+1:2];
  assign sdata = a_neg ? ~a_wdata + 32'd1 : a_wdata;
  assign ready = state == IDLE;
  assign rvalid = state == RESP;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      rdata <= '0;
      err <= 1'b0;
      c_we <= 1'b0;
      c_neg <= 1'b0;
      c_addr <= '0;
      c_wdata <= '0;
    end else begin
      state <= idle_go ? (WC == 4'd0 ? RESP : WAIT) :
               state == WAIT && cnt == 4'd1 ? RESP :
               state == RESP ? IDLE : state;
      cnt <= idle_go ? WC : state == WAIT ? cnt - 4'd1 : cnt;
      if (idle_go) begin
        c_we <= we;
        c_neg <= neg;
        c_addr <= addr;
        c_wdata <= wdata;
      end
      if (fire) begin
        err <= bad;
        rdata <= (bad || a_we) ? '0 : mem[idx];
      end
    end
  end
  always_ff @(posedge clk) begin
    if (fire && a_we && !bad) mem[idx] <= sdata;
  end
endmodule
